// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter.
// FSM encoding and the requester index width helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Searches upward from last_winner+1, wrapping.
module uart_rr_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int n_req = 4,
    localparam int IW = idx_w(n_req)
) (
    input  logic [n_req-1:0] i_req,
    input  logic [IW-1:0]    i_last_winner,
    output logic [IW-1:0]    o_winner,
    output logic             o_any
);

    logic          w_found;
    logic [IW-1:0] w_pos;
    int            w_sum;

    // First requester after the previous winner, modulo n_req
    always_comb begin
        w_found  = 1'b0;
        o_winner = '0;
        w_pos    = '0;
        w_sum    = 0;
        for (int i = 1; i <= n_req; i++) begin
            w_sum = (int'(i_last_winner) + i) % n_req;
            w_pos = IW'(w_sum);
            if (!w_found && i_req[w_pos]) begin
                w_found  = 1'b1;
                o_winner = w_pos;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of one UART TX.
// Holds a grant for a whole packet; one byte in flight at a time.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int n_req        = 4,
    parameter int idle_timeout = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [n_req-1:0]     req_valid,
    input  logic [8*n_req-1:0]   req_data,
    input  logic [n_req-1:0]     req_last,
    output logic [n_req-1:0]     req_ready,
    output logic [n_req-1:0]     grant,
    output logic                 busy,
    output logic [7:0]           uart_data_tx,
    output logic                 uart_start_transmit,
    input  logic                 uart_end_transmit
);

    localparam int IW = idx_w(n_req);
    localparam int TW = (idle_timeout > 0) ? $clog2(idle_timeout + 1) : 1;
    localparam logic [TW-1:0]    TMO_LAST = TW'(idle_timeout - 1);
    localparam logic [IW-1:0]    IDX_LAST = IW'(n_req - 1);
    localparam logic [n_req-1:0] ONE      = n_req'(1);

    state_t             r_state, w_state_nxt;
    logic [n_req-1:0]   r_grant, w_grant_nxt;
    logic [IW-1:0]      r_gidx, w_gidx_nxt;
    logic [IW-1:0]      r_last_winner, w_last_winner_nxt;
    logic [7:0]         r_data, w_data_nxt;
    logic               r_last, w_last_nxt;
    logic               r_start, w_start_nxt;
    logic [TW-1:0]      r_tmo, w_tmo_nxt;
    logic [n_req-1:0]   w_ready;

    logic [IW-1:0]      w_winner;
    logic               w_any;
    logic               w_valid_g;
    logic               w_last_g;
    logic [7:0]         w_byte_g;

    uart_rr_picker #(
        .n_req (n_req)
    ) u_picker (
        .i_req         (req_valid),
        .i_last_winner (r_last_winner),
        .o_winner      (w_winner),
        .o_any         (w_any)
    );

    // Select the granted lane's valid, last and byte
    always_comb begin
        w_valid_g = 1'b0;
        w_last_g  = 1'b0;
        w_byte_g  = 8'h00;
        for (int i = 0; i < n_req; i++) begin
            if (r_gidx == IW'(i)) begin
                w_valid_g = req_valid[i];
                w_last_g  = req_last[i];
                w_byte_g  = req_data[8*i +: 8];
            end
        end
    end

    // Next-state and datapath updates for the packet FSM
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_gidx_nxt        = r_gidx;
        w_last_winner_nxt = r_last_winner;
        w_data_nxt        = r_data;
        w_last_nxt        = r_last;
        w_start_nxt       = 1'b0;
        w_tmo_nxt         = r_tmo;
        w_ready           = '0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_nxt = ONE << w_winner;
                    w_gidx_nxt  = w_winner;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_ready = r_grant;
                if (w_valid_g) begin
                    w_data_nxt  = w_byte_g;
                    w_last_nxt  = w_last_g;
                    w_start_nxt = 1'b1;
                    w_tmo_nxt   = '0;
                    w_state_nxt = WAIT;
                end else if (idle_timeout != 0) begin
                    if (r_tmo == TMO_LAST) begin
                        w_last_winner_nxt = r_gidx;
                        w_grant_nxt       = '0;
                        w_tmo_nxt         = '0;
                        w_state_nxt       = IDLE;
                    end else begin
                        w_tmo_nxt = r_tmo + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (uart_end_transmit) begin
                    if (r_last) begin
                        w_last_winner_nxt = r_gidx;
                        w_grant_nxt       = '0;
                        w_state_nxt       = IDLE;
                    end else begin
                        w_state_nxt = FETCH;
                    end
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_gidx        <= '0;
            r_last_winner <= IDX_LAST;
            r_data        <= 8'h00;
            r_last        <= 1'b0;
            r_start       <= 1'b0;
            r_tmo         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_gidx        <= w_gidx_nxt;
            r_last_winner <= w_last_winner_nxt;
            r_data        <= w_data_nxt;
            r_last        <= w_last_nxt;
            r_start       <= w_start_nxt;
            r_tmo         <= w_tmo_nxt;
        end
    end

    assign req_ready           = w_ready;
    assign grant               = r_grant;
    assign busy                = (r_state != IDLE);
    assign uart_data_tx        = r_data;
    assign uart_start_transmit = r_start;

endmodule
